// File: rtl/vr_pkg.sv
// Shared definitions for the valid/ready skid buffer.
//   vr_state_e     : buffer fill state (EMPTY / BUSY / FULL)
//   DATA_W_DEFAULT : default payload width
package vr_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } vr_state_e;

    localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/vr_data_reg.sv
// Load-enable data register with synchronous active-high clear.
//   clk  : clock
//   rst  : synchronous reset, clears q to 0
//   ld   : load d into q on the next rising edge
//   d    : data in
//   q    : registered data out
module vr_data_reg
    import vr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/vr_skid_buffer.sv
// Two-entry valid/ready skid buffer. All handshake outputs decode from
// state_q only, so there is no combinational path from dst_ready to
// src_ready.
//   clk, rst   : clock, synchronous active-high reset
//   src_valid  : producer offers src_data
//   src_data   : producer payload
//   src_ready  : buffer accepts a word this cycle
//   dst_valid  : dst_data holds a valid word
//   dst_data   : oldest buffered word (main_q)
//   dst_ready  : consumer takes dst_data this cycle
//   occupancy  : buffered word count, 0..2
module vr_skid_buffer
    import vr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              dst_valid,
    output logic [DATA_W-1:0] dst_data,
    input  logic              dst_ready,
    output logic [1:0]        occupancy
);

    vr_state_e         state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q, main_d;
    logic              main_ld, main_sel_skid, skid_ld;
    logic              in_xfer, out_xfer;

    assign src_ready = (state_q != FULL);
    assign dst_valid = (state_q != EMPTY);
    assign dst_data  = main_q;
    assign occupancy = (state_q == FULL) ? 2'd2 :
                       (state_q == BUSY) ? 2'd1 : 2'd0;

    assign in_xfer  = src_valid && src_ready;
    assign out_xfer = dst_valid && dst_ready;

    always_comb begin
        state_d       = state_q;
        main_ld       = 1'b0;
        main_sel_skid = 1'b0;
        skid_ld       = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_ld = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && !out_xfer) begin
                    // consumer stalled: park the new word behind main_q
                    skid_ld = 1'b1;
                    state_d = FULL;
                end else if (!in_xfer && out_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer && out_xfer) begin
                    main_ld = 1'b1;
                end
            end
            FULL: begin
                // src_ready is low here, so only the drain side can move
                if (out_xfer) begin
                    main_ld       = 1'b1;
                    main_sel_skid = 1'b1;
                    state_d       = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign main_d = main_sel_skid ? skid_q : src_data;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    vr_data_reg #(.DATA_W(DATA_W)) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    vr_data_reg #(.DATA_W(DATA_W)) u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (skid_ld),
        .d   (src_data),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_vr_skid_buffer.sv
module tb_vr_skid_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic        src_ready;
    logic        dst_valid;
    logic [31:0] dst_data;
    logic        dst_ready = 1'b0;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb[$];
    int          model_occ = 0;
    logic        last_in = 1'b0;
    int          max_occ = 0;

    always #5 clk = ~clk;

    vr_skid_buffer #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_ready (dst_ready),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // compare all outputs against the reference model (called at negedge)
    task automatic check_outputs();
        chk("src_ready", {31'd0, src_ready}, {31'd0, model_occ != 2});
        chk("dst_valid", {31'd0, dst_valid}, {31'd0, model_occ != 0});
        chk("occupancy", {30'd0, occupancy}, model_occ);
        if (model_occ != 0)
            chk("dst_data", dst_data, sb[0]);
        if (model_occ > max_occ) max_occ = model_occ;
    endtask

    // one clock cycle: check current outputs, drive inputs, advance model
    task automatic tick(input logic sv, input logic [31:0] sd, input logic dr);
        logic in_x, out_x;
        check_outputs();
        src_valid = sv;
        src_data  = sd;
        dst_ready = dr;
        in_x  = sv && (model_occ != 2);
        out_x = dr && (model_occ != 0);
        if (out_x) void'(sb.pop_front());
        if (in_x)  sb.push_back(sd);
        model_occ = sb.size();
        last_in   = in_x;
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        src_valid = 1'b1;            // reset must dominate a pending transfer
        src_data  = 32'h5555_AAAA;
        dst_ready = 1'b1;
        repeat (cycles) @(negedge clk);
        rst       = 1'b0;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        sb.delete();
        model_occ = 0;
        chk("rst_data", dst_data, 32'h0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (model_occ != 0 && n < 10) begin
            tick(1'b0, 32'h0, 1'b1);
            n++;
        end
        chk({tag, "_drained"}, model_occ, 0);
    endtask

    initial begin
        int pushed;
        int cyc;

        // reset then idle
        @(negedge clk);
        do_reset(2);
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b1);

        // single word
        tick(1'b1, 32'h0000_00A5, 1'b1);
        chk("single_vld", {31'd0, dst_valid}, 32'd1);
        chk("single_dat", dst_data, 32'h0000_00A5);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);

        // streaming 1..8 with dst_ready high
        max_occ = 0;
        for (int i = 1; i <= 8; i++)
            tick(1'b1, i, 1'b1);
        drain("stream");
        chk("stream_maxocc", max_occ, 1);

        // fill and drain under backpressure
        tick(1'b1, 32'hDEAD_BEEF, 1'b0);
        tick(1'b1, 32'hCAFE_F00D, 1'b0);
        chk("fill_occ", {30'd0, occupancy}, 2);
        chk("fill_srdy", {31'd0, src_ready}, 0);
        tick(1'b1, 32'h1111_1111, 1'b0);      // refused while FULL
        chk("fill_hold", dst_data, 32'hDEAD_BEEF);
        tick(1'b0, 32'h0, 1'b1);
        chk("fill_next", dst_data, 32'hCAFE_F00D);
        chk("fill_srdy_back", {31'd0, src_ready}, 1);
        drain("fill");

        // random valid/ready
        pushed = 0;
        cyc    = 0;
        while (pushed < 1000 && cyc < 6000) begin
            tick(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if (last_in) pushed++;
            cyc++;
        end
        chk("rand_pushed", pushed, 1000);
        drain("rand");

        // reset mid-operation from FULL
        tick(1'b1, 32'h0BAD_0001, 1'b0);
        tick(1'b1, 32'h0BAD_0002, 1'b0);
        chk("mid_full", {30'd0, occupancy}, 2);
        do_reset(1);
        chk("mid_occ", {30'd0, occupancy}, 0);
        chk("mid_vld", {31'd0, dst_valid}, 0);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b1, 32'h1234_5678, 1'b0);
        chk("mid_new", dst_data, 32'h1234_5678);
        drain("mid");
        tick(1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vr_skid_buffer.md
# vr_skid_buffer

Two-entry valid/ready skid buffer that decouples a 32-bit producer from a 32-bit consumer. It sits between pipeline stages such as the operand capture register and the downstream compute/output logic. It accepts one word per cycle on its receive side and presents words in order on its transmit side. Ready and valid are fully registered, so no combinational path runs between `dst_ready` and `src_ready`.

## Interface
- `DATA_W`, 32, payload width in bits.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `src_valid`  input  1  producer offers `src_data`.
- `src_data`  input  DATA_W  producer payload.
- `src_ready`  output  1  buffer can accept a word this cycle.
- `dst_valid`  output  1  `dst_data` holds a valid word.
- `dst_data`  output  DATA_W  oldest buffered word.
- `dst_ready`  input  1  consumer takes `dst_data` this cycle.
- `occupancy`  output  2  number of buffered words, 0 to 2.

## Operation
- Transfer rules:
  - Input transfer (`in_xfer`) occurs when `src_valid && src_ready` at a rising edge.
  - Output transfer (`out_xfer`) occurs when `dst_valid && dst_ready` at a rising edge.
- Storage is `main_q`, which drives `dst_data`, plus `skid_q`, which holds the overflow word.
- State register `state_q`:
  - EMPTY: `occupancy` 0.
  - BUSY: `occupancy` 1.
  - FULL: `occupancy` 2.
- All outputs decode from registers only:
  - `src_ready = (state_q != FULL)`
  - `dst_valid = (state_q != EMPTY)`
  - `dst_data = main_q`
- Transitions:
  - EMPTY, `in_xfer`: `main_q <= src_data`, go to BUSY. Otherwise stay in EMPTY.
  - BUSY, `in_xfer && !out_xfer`: `skid_q <= src_data`, go to FULL.
  - BUSY, `!in_xfer && out_xfer`: go to EMPTY; `main_q` is left unchanged.
  - BUSY, `in_xfer && out_xfer`: `main_q <= src_data`, stay in BUSY.
  - BUSY, neither transfer: hold.
  - FULL, `out_xfer`: `main_q <= skid_q`, go to BUSY. `in_xfer` cannot occur in FULL because `src_ready` is 0.
  - FULL, no `out_xfer`: hold.
- Words exit in strict arrival order. None is lost or duplicated.
- `dst_data` must stay stable while `dst_valid && !dst_ready`.
- A producer that drops `src_valid` without a transfer has no effect. The buffer never relies on producer stability.
- Unused state encoding: the next state is EMPTY.

## Timing
- Reset, sampled high at a rising edge, forces:
  - `state_q` = EMPTY
  - `main_q` = 0 and `skid_q` = 0
  - `dst_valid` = 0, `dst_data` = 0, `occupancy` = 0
  - `src_ready` = 1 from the first cycle after reset.
- Reset dominates all transfers in the same cycle.
- Reset mid-operation discards any buffered words.
- Latency: a word accepted at edge N is visible on `dst_data` with `dst_valid` = 1 after edge N.
- Throughput: sustained one word per cycle while `dst_ready` stays high.
- Backpressure:
  - `src_ready` falls one cycle after the buffer becomes FULL.
  - The in-flight word on that edge is captured in `skid_q`.
  - `src_ready` rises the cycle after the first `out_xfer` out of FULL.
- Simultaneous events:
  - BUSY with both transfers keeps `occupancy` at 1.
  - FULL with `out_xfer` gives `occupancy` 1. `src_ready` is high on the following cycle only.

## Structure
- Shared package `vr_pkg` holds:
  - `typedef enum logic [1:0] {EMPTY, BUSY, FULL} vr_state_e`
  - `localparam DATA_W_DEFAULT = 32`
- One sub-module, `vr_data_reg`, is a DATA_W-wide load-enable register with synchronous active-high reset to 0.
  - It is instantiated twice: once for `main_q` and once for `skid_q`.
- Top level contains only the state register, next-state logic and the load-enable / mux select for `main_q`.

## Test plan
- Reset then idle: hold `rst` for 2 cycles, release -> `src_ready` = 1, `dst_valid` = 0, `dst_data` = 0, `occupancy` = 0.
- Single word: send 0x0000_00A5 with `dst_ready` = 1 -> `dst_valid` = 1 with `dst_data` 0x0000_00A5 one cycle later, then back to EMPTY.
- Streaming: 8 consecutive words 0x1..0x8, `dst_ready` always 1 -> output in order 0x1..0x8 on consecutive cycles, `occupancy` never exceeds 1.
- Fill and drain:
  - Stimulus: `dst_ready` = 0, send 0xDEAD_BEEF then 0xCAFE_F00D, then release `dst_ready`.
  - Response: `occupancy` reaches 2 and `src_ready` = 0; `dst_data` holds 0xDEAD_BEEF until released, then shows 0xCAFE_F00D; `src_ready` returns to 1.
- Random valid/ready: 1000 words with random `src_valid` and `dst_ready` at 50% -> scoreboard shows exact order, `dst_data` stable under stall, no loss or duplication.
- Reset mid-operation: reach FULL, assert `rst` for 1 cycle -> EMPTY, `occupancy` 0, `dst_valid` 0, the old words are never output, and the next word sent is output correctly.
